// File: rtl/bw_frame_pkg.sv
// Shared constants and FSM state type for the 28x28 black/white frame server.
package bw_frame_pkg;

    localparam int IMG_W      = 28;
    localparam int IMG_H      = 28;
    localparam int IMG_PIXELS = IMG_W * IMG_H;
    localparam int ADDR_W     = 10;
    localparam int COL_W      = $clog2(IMG_W);
    localparam int ROW_W      = $clog2(IMG_H);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        READY
    } state_t;

endpackage

// File: rtl/bw_bitmap_ram.sv
// IMG_PIXELS x 1 bitmap store: synchronous write, registered read, out-of-range reads return 1.
module bw_bitmap_ram
    import bw_frame_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic              wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_data_o
);

    localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(IMG_PIXELS);

    logic mem_q [IMG_PIXELS];
    logic rd_data_q;

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && (wr_addr_i < ADDR_LIM)) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= 1'b1;
        end else begin
            rd_data_q <= (rd_addr_i < ADDR_LIM) ? mem_q[rd_addr_i] : 1'b1;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/bw_frame_server.sv
// Camera-side capture: decimates a SCALE x SCALE source window to 28x28, thresholds, stores, serves reads.
// Optional macro BW_FRAME_DOUBLE_BUFFER_EN adds a second bank so capture can overlap classifier reads.
module bw_frame_server
    import bw_frame_pkg::*;
#(
    parameter int SCALE     = 10,
    parameter int GRAY_W    = 8,
    parameter int THRESHOLD = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_photo,
    input  logic              sof,
    input  logic              pix_valid,
    input  logic [GRAY_W-1:0] pix_gray,
    input  logic [ADDR_W-1:0] pixel_addr,
    output logic              pixel,
    output logic              load,
    input  logic              consumer_done,
    output logic              busy,
    output state_t            dbg_state_o
);

    localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [SUB_W-1:0]  SUB_MID   = SUB_W'(SCALE / 2);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(SCALE - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_PIXELS - 1);
    localparam logic [GRAY_W-1:0] THRESH    = GRAY_W'(THRESHOLD);

    state_t            state_q;
    logic              load_q, busy_q, pend_q;
    logic [SUB_W-1:0]  col_sub_q, col_sub_d, row_sub_q, row_sub_d;
    logic [COL_W-1:0]  dst_col_q, dst_col_d;
    logic [ROW_W-1:0]  dst_row_q, dst_row_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

    logic [SUB_W-1:0]  pos_col_sub, pos_row_sub;
    logic [COL_W-1:0]  pos_dst_col;
    logic [ROW_W-1:0]  pos_dst_row;
    logic [ADDR_W-1:0] wr_addr;
    logic              cap_cycle, wr_en, wr_bit, frame_done;

    // pix_valid qualifies sof and pix_gray; the source has no backpressure, so every
    // valid sample is consumed in the cycle it is presented.
    always_comb begin
        cap_cycle   = pix_valid && (((state_q == ARMED) && sof) || (state_q == CAPTURE));
        pos_col_sub = sof ? '0 : col_sub_q;
        pos_row_sub = sof ? '0 : row_sub_q;
        pos_dst_col = sof ? '0 : dst_col_q;
        pos_dst_row = sof ? '0 : dst_row_q;
        wr_addr     = sof ? '0 : wr_addr_q;
        wr_en       = cap_cycle && (pos_col_sub == SUB_MID) && (pos_row_sub == SUB_MID);
        wr_bit      = (pix_gray >= THRESH);
        frame_done  = wr_en && (wr_addr == ADDR_LAST);
        wr_addr_d   = wr_en ? wr_addr + 1'b1 : wr_addr;
        col_sub_d   = pos_col_sub;
        row_sub_d   = pos_row_sub;
        dst_col_d   = pos_dst_col;
        dst_row_d   = pos_dst_row;
        if (pos_col_sub != SUB_LAST) begin
            col_sub_d = pos_col_sub + 1'b1;
        end else begin
            col_sub_d = '0;
            if (pos_dst_col != COL_LAST) begin
                dst_col_d = pos_dst_col + 1'b1;
            end else begin
                dst_col_d = '0;
                if (pos_row_sub != SUB_LAST) begin
                    row_sub_d = pos_row_sub + 1'b1;
                end else begin
                    row_sub_d = '0;
                    dst_row_d = (pos_dst_row == ROW_LAST) ? '0 : pos_dst_row + 1'b1;
                end
            end
        end
    end

`ifdef BW_FRAME_DOUBLE_BUFFER_EN
    logic front_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
            pend_q    <= 1'b0;
            col_sub_q <= '0;
            row_sub_q <= '0;
            dst_col_q <= '0;
            dst_row_q <= '0;
            wr_addr_q <= '0;
`ifdef BW_FRAME_DOUBLE_BUFFER_EN
            front_q   <= 1'b0;
`endif
        end else begin
            if (cap_cycle) begin
                col_sub_q <= col_sub_d;
                row_sub_q <= row_sub_d;
                dst_col_q <= dst_col_d;
                dst_row_q <= dst_row_d;
                wr_addr_q <= wr_addr_d;
            end
            case (state_q)
                IDLE: begin
                    if (take_photo || pend_q) begin
                        state_q <= ARMED;
                        busy_q  <= 1'b1;
                        pend_q  <= 1'b0;
                    end
                end
                ARMED, CAPTURE: begin
                    if (take_photo) pend_q <= 1'b1;
                    if (cap_cycle) begin
                        if (frame_done) begin
                            state_q <= READY;
                            busy_q  <= 1'b0;
                            load_q  <= 1'b1;
`ifdef BW_FRAME_DOUBLE_BUFFER_EN
                            front_q <= ~front_q;
`endif
                        end else begin
                            state_q <= CAPTURE;
                        end
                    end
                end
                READY: begin
`ifdef BW_FRAME_DOUBLE_BUFFER_EN
                    if (take_photo || pend_q) begin
                        state_q <= ARMED;
                        busy_q  <= 1'b1;
                        pend_q  <= 1'b0;
                    end else if (consumer_done) begin
                        state_q <= IDLE;
                    end
`else
                    if (take_photo) pend_q <= 1'b1;
                    if (consumer_done) begin
                        state_q <= IDLE;
                        load_q  <= 1'b0;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
`ifdef BW_FRAME_DOUBLE_BUFFER_EN
            // A frame completing in the same cycle as consumer_done is newer and keeps load high.
            if (consumer_done && !frame_done) load_q <= 1'b0;
`endif
        end
    end

`ifdef BW_FRAME_DOUBLE_BUFFER_EN
    logic rd0, rd1;

    bw_bitmap_ram u_bank0 (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .wr_en_i   (wr_en && front_q),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_bit),
        .rd_addr_i (pixel_addr),
        .rd_data_o (rd0)
    );

    bw_bitmap_ram u_bank1 (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .wr_en_i   (wr_en && !front_q),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_bit),
        .rd_addr_i (pixel_addr),
        .rd_data_o (rd1)
    );

    assign pixel = front_q ? rd1 : rd0;
`else
    logic rd0;

    bw_bitmap_ram u_bank0 (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_bit),
        .rd_addr_i (pixel_addr),
        .rd_data_o (rd0)
    );

    assign pixel = rd0;
`endif

    assign load        = load_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bw_frame_server.sv
// Directed bench for bw_frame_server (SCALE=2 keeps each 56x56 source frame short).
module tb_bw_frame_server;
    import bw_frame_pkg::*;

    localparam int SCALE = 2;
    localparam int SRC_W = IMG_W * SCALE;
    localparam int SRC_H = IMG_H * SCALE;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              take_photo = 1'b0;
    logic              sof = 1'b0;
    logic              pix_valid = 1'b0;
    logic [7:0]        pix_gray = '0;
    logic [ADDR_W-1:0] pixel_addr = '0;
    logic              consumer_done = 1'b0;
    logic              pixel, load, busy;
    state_t            dbg_state;

    int checks = 0;
    int errors = 0;
    logic [0:0] exp_q[$];
    logic model_img [IMG_PIXELS];

    bw_frame_server #(.SCALE(SCALE), .GRAY_W(8), .THRESHOLD(128)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .take_photo    (take_photo),
        .sof           (sof),
        .pix_valid     (pix_valid),
        .pix_gray      (pix_gray),
        .pixel_addr    (pixel_addr),
        .pixel         (pixel),
        .load          (load),
        .consumer_done (consumer_done),
        .busy          (busy),
        .dbg_state_o   (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_px(input int a);
        if (a >= IMG_PIXELS) return 1'b1;
        return model_img[a];
    endfunction

    function automatic logic [7:0] gen_px(input int kind, input int r, input int c);
        case (kind)
            0: return 8'd200;
            1: return (r == 37 && c == 35) ? 8'd20 : 8'd255;
            2: return (r == 1 && c == 1) ? 8'd127 : ((r == 1 && c == 3) ? 8'd128 : 8'd0);
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // driver tasks
    task automatic pulse_take();
        take_photo = 1'b1;
        tick();
        take_photo = 1'b0;
    endtask

    task automatic pulse_done();
        consumer_done = 1'b1;
        tick();
        consumer_done = 1'b0;
    endtask

    task automatic drive_frame(input int kind, input int stop_row, input int tp_row);
        for (int r = 0; r < SRC_H; r++) begin
            if (r == stop_row) break;
            for (int c = 0; c < SRC_W; c++) begin
                logic [7:0] g;
                bit samp, last;
                if ($urandom_range(0, 9) == 0) begin
                    pix_valid  = 1'b0;
                    take_photo = 1'b0;
                    sof        = 1'($urandom_range(0, 1));
                    pix_gray   = 8'($urandom_range(0, 255));
                    tick();
                end
                g    = gen_px(kind, r, c);
                samp = (r % SCALE == SCALE / 2) && (c % SCALE == SCALE / 2);
                last = samp && (r / SCALE == IMG_H - 1) && (c / SCALE == IMG_W - 1);
                if (samp) model_img[(r / SCALE) * IMG_W + c / SCALE] = (g >= 8'd128);
                pix_valid  = 1'b1;
                sof        = (r == 0 && c == 0);
                pix_gray   = g;
                take_photo = (r == tp_row && c == 0);
                if (last) begin
                    check("load_before_last", 32'(load), 32'd0);
                    check("busy_before_last", 32'(busy), 32'd1);
                end
                tick();
                if (last) begin
                    check("load_after_last", 32'(load), 32'd1);
                    check("busy_after_last", 32'(busy), 32'd0);
                    check("state_after_last", 32'(dbg_state), 32'(READY));
                end
            end
        end
        pix_valid  = 1'b0;
        sof        = 1'b0;
        take_photo = 1'b0;
    endtask

    // scoreboard: expected bit queued with the address, compared when pixel returns
    task automatic read_exp(input int a, input logic e);
        logic [0:0] got_exp;
        pixel_addr = ADDR_W'(a);
        exp_q.push_back(e);
        tick();
        got_exp = exp_q.pop_front();
        check($sformatf("rd[%0d]", a), 32'(pixel), 32'(got_exp));
    endtask

    task automatic read_all();
        for (int a = 0; a < IMG_PIXELS; a++) read_exp(a, exp_px(a));
    endtask

    initial begin
        int z;
        for (int i = 0; i < IMG_PIXELS; i++) model_img[i] = 1'b1;

        // reset state
        repeat (3) tick();
        check("rst_load", 32'(load), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pixel", 32'(pixel), 32'd1);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        reset_n = 1'b1;
        tick();

        // consumer_done outside READY is ignored
        pulse_done();
        check("done_idle_state", 32'(dbg_state), 32'(IDLE));
        check("done_idle_load", 32'(load), 32'd0);

        // all-white capture; ARMED ignores samples until sof
        pulse_take();
        check("armed_state", 32'(dbg_state), 32'(ARMED));
        check("armed_busy", 32'(busy), 32'd1);
        pix_valid = 1'b1;
        pix_gray  = 8'd0;
        repeat (5) tick();
        pix_valid = 1'b0;
        check("armed_wait_sof", 32'(dbg_state), 32'(ARMED));
        drive_frame(0, -1, -1);
        pix_valid = 1'b1;
        pix_gray  = 8'd0;
        repeat (3) tick();
        sof = 1'b1;
        tick();
        sof = 1'b0;
        pix_valid = 1'b0;
        check("ready_ignores_pixels", 32'(dbg_state), 32'(READY));
        read_exp(0, 1'b1);
        read_exp(391, 1'b1);
        read_exp(783, 1'b1);
        read_exp(900, 1'b1);
        pulse_done();
        check("done_load_low", 32'(load), 32'd0);
        check("done_state_idle", 32'(dbg_state), 32'(IDLE));

        // ink pattern
        pulse_take();
        drive_frame(1, -1, -1);
        read_exp(521, 1'b0);
        read_exp(520, 1'b1);
        read_exp(522, 1'b1);
        read_all();

        // consumer_done and take_photo together in READY
        consumer_done = 1'b1;
        take_photo    = 1'b1;
        tick();
        consumer_done = 1'b0;
        take_photo    = 1'b0;
        check("both_state_idle", 32'(dbg_state), 32'(IDLE));
        check("both_load_low", 32'(load), 32'd0);
        tick();
        check("both_state_armed", 32'(dbg_state), 32'(ARMED));

        // threshold edge, with take_photo latched during CAPTURE
        drive_frame(2, -1, 10);
        read_exp(0, 1'b0);
        read_exp(1, 1'b1);
        read_exp(2, 1'b0);
        read_all();
        pulse_done();
        check("pend_state_idle", 32'(dbg_state), 32'(IDLE));
        check("pend_load_low", 32'(load), 32'd0);
        tick();
        check("pend_state_armed", 32'(dbg_state), 32'(ARMED));

        // sof mid-frame restarts the capture
        drive_frame(3, 20, -1);
        check("restart_load_low", 32'(load), 32'd0);
        check("restart_state", 32'(dbg_state), 32'(CAPTURE));
        drive_frame(3, -1, -1);
        read_all();
        pulse_done();
        check("restart_done_idle", 32'(dbg_state), 32'(IDLE));

        // reset mid-capture with a pending request
        z = 300;
        for (int i = IMG_PIXELS - 1; i >= 300; i--) if (model_img[i] == 1'b0) z = i;
        pulse_take();
        drive_frame(3, 10, 3);
        pixel_addr = ADDR_W'(z);
        tick();
        reset_n = 1'b0;
        #1;
        check("midrst_load", 32'(load), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_pixel", 32'(pixel), 32'd1);
        check("midrst_state", 32'(dbg_state), 32'(IDLE));
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("midrst_pend_cleared", 32'(dbg_state), 32'(IDLE));
        check("midrst_busy_after", 32'(busy), 32'd0);
        pulse_take();
        drive_frame(3, -1, -1);
        read_all();
        read_exp(1023, 1'b1);
        pulse_done();
        check("final_load_low", 32'(load), 32'd0);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bw_frame_server.md
Name: bw_frame_server

Overview:
- Capture-side producer for the digit-recognition path.
- Takes a grayscale camera pixel stream, decimates one SCALE x SCALE source window to a 28x28 image, thresholds each pixel to 1 bit, and stores the image.
- Once a full frame is stored, raises load and serves single-bit reads on pixel_addr to the LCD classifier until the classifier signals done.

Parameters:
- IMG_W, 28, output image width in pixels.
- IMG_H, 28, output image height in pixels.
- SCALE, 10, source-to-output decimation factor. Source window is IMG_W*SCALE x IMG_H*SCALE.
- GRAY_W, 8, grayscale sample width.
- THRESHOLD, 128, a sample >= THRESHOLD maps to 1 (background/white); anything lower maps to 0 (ink).
- ADDR_W, 10, read address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- take_photo  in  1  single-cycle capture request.
- sof  in  1  start-of-frame strobe, qualified by pix_valid; marks the first pixel of a source frame.
- pix_valid  in  1  pix_gray is valid this cycle.
- pix_gray  in  GRAY_W  grayscale sample, raster order.
- pixel_addr  in  ADDR_W  read address = row*IMG_W + col.
- pixel  out  1  read data for the address presented one cycle earlier.
- load  out  1  a stored frame is valid and readable (photo_taken_ready).
- consumer_done  in  1  single-cycle pulse from the classifier (its complete output); releases the frame.
- busy  out  1  a capture is armed or in progress.

Behaviour:
- Reset values: load=0, busy=0, pixel=1, FSM=IDLE, all counters 0. Image storage is not cleared.
- IDLE:
  - take_photo -> ARMED.
- ARMED (busy=1):
  - Waits for pix_valid&sof.
  - On that cycle the first sample is processed and the FSM goes to CAPTURE.
- CAPTURE (busy=1):
  - Every pix_valid advances the source counters: col_sub 0..SCALE-1, dst_col 0..IMG_W-1, row_sub 0..SCALE-1, dst_row 0..IMG_H-1, raster order.
  - A sample is written only when col_sub==SCALE/2 and row_sub==SCALE/2.
  - Written bit = (pix_gray >= THRESHOLD). Write address = dst_row*IMG_W + dst_col, kept as an incrementing counter with no multiplier.
  - The write of address IMG_W*IMG_H-1 completes the frame: next cycle FSM=READY and load=1.
  - Samples after that point in the source frame are ignored.
- READY (load=1, busy=0):
  - pixel is registered from storage[pixel_addr], one cycle of latency, every cycle.
  - On consumer_done: load=0 the following cycle, FSM=IDLE.
- Boundary conditions:
  - pixel_addr >= IMG_W*IMG_H reads as 1.
  - sof during CAPTURE restarts the frame: counters return to the sof sample's position and writes restart at address 0.
  - take_photo while busy or READY is latched as a pending request; it is serviced on the next entry to IDLE, moving to ARMED one cycle later.
  - consumer_done outside READY is ignored.
  - consumer_done and take_photo in the same cycle in READY: READY->IDLE, then ARMED.
  - pix_valid low stalls all counters.
  - Reset asserted mid-capture: immediate return to IDLE with load=0 and the pending request cleared.

Optional Feature:
- Macro: BW_FRAME_DOUBLE_BUFFER_EN.
- With the macro defined:
  - Two image banks. Capture writes the back bank; reads come from the front bank.
  - On capture completion the banks swap and load=1.
  - take_photo is accepted in READY, and a new capture runs while the classifier reads the previous image.
  - consumer_done clears load only if no newer frame completed. A swap while load=1 keeps load=1.
- Without it: single bank, behaviour exactly as above. Reads are valid only while load=1.

Decomposition:
- Package bw_frame_pkg holds:
  - IMG_W, IMG_H, IMG_PIXELS = IMG_W*IMG_H, ADDR_W constants.
  - The FSM state enum (IDLE, ARMED, CAPTURE, READY).
- Natural sub-module: bw_bitmap_ram.
  - IMG_PIXELS x 1 storage, one synchronous write port and one registered read port.
  - Out-of-range read returns 1.
  - Instanced twice under BW_FRAME_DOUBLE_BUFFER_EN.

Test Plan:
- All-white capture: take_photo, then a 280x280 frame with sof on the first sample, all 8'd200 -> load=1 after the last sampled pixel; reads of addr 0, 391, 783 return 1 one cycle later.
- Ink pattern: source pixel (row 185, col 175) = 8'd20, all others 8'd255 -> only addr 18*28+17=521 reads 0; addr 520 and 522 read 1.
- Threshold edge: sampled values 127 and 128 -> bits 0 and 1 respectively.
- Handshake: consumer_done pulse in READY -> load=0 next cycle. take_photo during CAPTURE -> ARMED one cycle after the following IDLE entry. addr 900 reads 1.
- Restart: sof mid-frame at source row 100 -> capture completes only after a further full 280x280 frame, and contents match the second frame.
- Reset mid-capture: reset_n low at source row 50 -> load=0, busy=0, pixel=1 immediately. A fresh take_photo plus frame completes normally. With BW_FRAME_DOUBLE_BUFFER_EN, run a back-to-back capture while reading the first frame -> old data is stable until the swap.
